kb_uart_ctrl: RTL

- Sequencer between the keyboard scan-code buffer (kb_code) and the UART transmit FIFO (uart).
- Pops one key code at a time and forwards its ASCII equivalent (from the external key2ascii converter) into the UART TX FIFO, honouring tx_full.
- Expands Enter into CR+LF and keeps a wrapping count of keys forwarded.
- Replaces the free-running, unthrottled buffer-to-UART connection in the keyboard test top level.

---
 rtl/kb_uart_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/kb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kb_uart_ctrl
// Purpose  : Sequencer between the keyboard scan-code buffer and the UART
//            transmit FIFO. Pops one key code at a time and forwards the
//            ASCII equivalent supplied by the external key2ascii converter.
//            Writes wait while tx_full is high. Enter (0x0D) can be expanded
//            into CR+LF. A wrapping count of forwarded keys is kept.
//
// Optional : KB_HEX_ECHO_EN - when defined, each key is followed by the two
//            hex digits of its scan code and a space. HEX_UPPER selects
//            upper- or lower-case digits A-F.
//
// Ports    : clk           system clock, rising edge
//            reset         asynchronous reset, active low
//            kb_buf_empty  keyboard buffer empty flag
//            key_code      keyboard buffer head (first-word-fall-through)
//            ascii_code    key2ascii translation of key_code (combinational)
//            tx_full       UART TX FIFO full flag
//            rd_key_code   one-cycle pop strobe to the keyboard buffer
//            wr_uart       one-cycle write strobe to the UART TX FIFO
//            w_data        byte to the UART, valid while wr_uart=1
//            busy          high whenever the sequencer is not idle
//            key_count     number of keys fully forwarded, modulo 2^CNT_W
//
// Revision : 1.0 - initial release
// ============================================================================
module kb_uart_ctrl #(
    parameter int unsigned CRLF_EN   = 1,
`ifdef KB_HEX_ECHO_EN
    parameter int unsigned HEX_UPPER = 1,
`endif
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kb_buf_empty,
    input  logic [7:0]       key_code,
    input  logic [7:0]       ascii_code,
    input  logic             tx_full,
    output logic             rd_key_code,
    output logic             wr_uart,
    output logic [7:0]       w_data,
    output logic             busy,
    output logic [CNT_W-1:0] key_count
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_POP      = 3'd1;
    localparam logic [2:0] c_ST_SEND_CHR = 3'd2;
    localparam logic [2:0] c_ST_SEND_LF  = 3'd3;
    localparam logic [2:0] c_ST_DONE     = 3'd4;
`ifdef KB_HEX_ECHO_EN
    localparam logic [2:0] c_ST_HEX_HI   = 3'd5;
    localparam logic [2:0] c_ST_HEX_LO   = 3'd6;
    localparam logic [2:0] c_ST_SEP      = 3'd7;
    localparam logic [7:0] c_ASCII_SP    = 8'h20;
`endif

    localparam logic [7:0]       c_ASCII_CR = 8'h0D;
    localparam logic [7:0]       c_ASCII_LF = 8'h0A;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = 1;

    logic [2:0]       state_q, state_d;
    logic [7:0]       kc_q, kc_d;
    logic [7:0]       ac_q, ac_d;
    logic [CNT_W-1:0] key_count_q, key_count_d;
    logic             rd_key_code_q, rd_key_code_d;
    logic             busy_q, busy_d;

    // State that follows the character (and the LF, when one is sent).
    logic [2:0]       w_after_text;

`ifdef KB_HEX_ECHO_EN
    assign w_after_text = c_ST_HEX_HI;

    function automatic logic [7:0] hex_digit(input logic [3:0] nib);
        logic [7:0] alpha_base;
        alpha_base = (HEX_UPPER != 0) ? 8'h41 : 8'h61;
        if (nib < 4'd10) begin
            hex_digit = 8'h30 + {4'h0, nib};
        end else begin
            hex_digit = alpha_base + {4'h0, nib - 4'd10};
        end
    endfunction
`else
    assign w_after_text = c_ST_DONE;

    // The scan code is latched for the hex echo only; without it the
    // latched value has no consumer.
    logic unused_kc;
    assign unused_kc = ^kc_q;
`endif

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= c_ST_IDLE;
            kc_q          <= 8'h00;
            ac_q          <= 8'h00;
            key_count_q   <= '0;
            rd_key_code_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            kc_q          <= kc_d;
            ac_q          <= ac_d;
            key_count_q   <= key_count_d;
            rd_key_code_q <= rd_key_code_d;
            busy_q        <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        kc_d        = kc_q;
        ac_d        = ac_q;
        key_count_d = key_count_q;
        case (state_q)
            c_ST_IDLE: begin
                if (!kb_buf_empty) begin
                    state_d = c_ST_POP;
                end
            end
            c_ST_POP: begin
                // The buffer head is captured on the pop edge so later
                // changes on key_code/ascii_code cannot disturb the send.
                kc_d    = key_code;
                ac_d    = ascii_code;
                state_d = c_ST_SEND_CHR;
            end
            c_ST_SEND_CHR: begin
                if (!tx_full) begin
                    if ((CRLF_EN != 0) && (ac_q == c_ASCII_CR)) begin
                        state_d = c_ST_SEND_LF;
                    end else begin
                        state_d = w_after_text;
                    end
                end
            end
            c_ST_SEND_LF: begin
                if (!tx_full) begin
                    state_d = w_after_text;
                end
            end
`ifdef KB_HEX_ECHO_EN
            c_ST_HEX_HI: begin
                if (!tx_full) begin
                    state_d = c_ST_HEX_LO;
                end
            end
            c_ST_HEX_LO: begin
                if (!tx_full) begin
                    state_d = c_ST_SEP;
                end
            end
            c_ST_SEP: begin
                if (!tx_full) begin
                    state_d = c_ST_DONE;
                end
            end
`endif
            c_ST_DONE: begin
                key_count_d = key_count_q + c_CNT_ONE;
                state_d     = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. rd_key_code and busy are registered from the next
    // state so they line up with the state they describe; wr_uart and
    // w_data are decoded directly so a write can follow tx_full at once.
    // ------------------------------------------------------------------
    always_comb begin
        rd_key_code_d = (state_d == c_ST_POP);
        busy_d        = (state_d != c_ST_IDLE);
        wr_uart       = 1'b0;
        w_data        = 8'h00;
        case (state_q)
            c_ST_SEND_CHR: begin
                w_data  = ac_q;
                wr_uart = !tx_full;
            end
            c_ST_SEND_LF: begin
                w_data  = c_ASCII_LF;
                wr_uart = !tx_full;
            end
`ifdef KB_HEX_ECHO_EN
            c_ST_HEX_HI: begin
                w_data  = hex_digit(kc_q[7:4]);
                wr_uart = !tx_full;
            end
            c_ST_HEX_LO: begin
                w_data  = hex_digit(kc_q[3:0]);
                wr_uart = !tx_full;
            end
            c_ST_SEP: begin
                w_data  = c_ASCII_SP;
                wr_uart = !tx_full;
            end
`endif
            default: begin
                wr_uart = 1'b0;
                w_data  = 8'h00;
            end
        endcase
    end

    assign rd_key_code = rd_key_code_q;
    assign busy        = busy_q;
    assign key_count   = key_count_q;

endmodule
`default_nettype wire
